// File: rtl/fma16_tv_writer.sv
// Test-vector writer for an external combinational fma16.
// It captures one operand vector, evaluates it for one cycle, then queues the result record in a FWFT FIFO.
module fma16_tv_writer #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  input  logic [15:0] in_z,
  input  logic [7:0]  in_ctrl,
  output logic [15:0] fma_x,
  output logic [15:0] fma_y,
  output logic [15:0] fma_z,
  output logic        fma_mul,
  output logic        fma_add,
  output logic        fma_negp,
  output logic        fma_negz,
  output logic [1:0]  fma_roundmode,
  input  logic [15:0] fma_result,
  input  logic [3:0]  fma_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [75:0] out_record,
  output logic [15:0] rec_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, EVAL} state_t;

  state_t        state_q, state_d;
  logic [15:0]   x_q, y_q, z_q;
  logic [7:0]    ctrl_q;
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   count_q;
  logic [15:0]   recCount_q;
  logic [75:0]   mem_q [DEPTH];

  logic accept, push, pop;

  // A slot is reserved at accept time; nothing else can fill the FIFO before the push.
  assign in_ready  = (state_q == IDLE) && (count_q < FULL);
  assign accept    = in_valid && in_ready;
  assign push      = (state_q == EVAL);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;

  assign fma_x         = x_q;
  assign fma_y         = y_q;
  assign fma_z         = z_q;
  assign fma_roundmode = ctrl_q[5:4];
  assign fma_mul       = ctrl_q[3];
  assign fma_add       = ctrl_q[2];
  assign fma_negp      = ctrl_q[1];
  assign fma_negz      = ctrl_q[0];

  assign out_record = mem_q[rdPtr_q];
  assign rec_count  = recCount_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = EVAL;
      EVAL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      ctrl_q     <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      recCount_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        x_q    <= in_x;
        y_q    <= in_y;
        z_q    <= in_z;
        ctrl_q <= in_ctrl;
      end
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW + 1)'(1);
      else if (pop && !push) count_q <= count_q - (AW + 1)'(1);
      if (push && recCount_q != 16'hFFFF) recCount_q <= recCount_q + 16'd1;
    end
  end

  // Storage is not reset; the head is only meaningful while out_valid is high.
  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wrPtr_q] <= {x_q, y_q, z_q, ctrl_q, fma_result, fma_flags};
  end

endmodule

// File: tb/tb_fma16_tv_writer.sv
// Self-checking bench for fma16_tv_writer: directed vector table, corner sequences and random traffic
// compared against a queue-based reference model with a deterministic fma16 stub.
module tb_fma16_tv_writer;

  localparam int DEPTH = 16;

  logic        clk;
  logic        reset;
  logic        inValid, inReady;
  logic [15:0] inX, inY, inZ;
  logic [7:0]  inCtrl;
  logic [15:0] fmaX, fmaY, fmaZ;
  logic        fmaMul, fmaAdd, fmaNegp, fmaNegz;
  logic [1:0]  fmaRoundmode;
  logic [15:0] fmaResult;
  logic [3:0]  fmaFlags;
  logic        outValid, outReady;
  logic [75:0] outRecord;
  logic [15:0] recCount;

  int nChecks = 0;
  int nFails  = 0;

  fma16_tv_writer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady),
    .in_x(inX), .in_y(inY), .in_z(inZ), .in_ctrl(inCtrl),
    .fma_x(fmaX), .fma_y(fmaY), .fma_z(fmaZ),
    .fma_mul(fmaMul), .fma_add(fmaAdd), .fma_negp(fmaNegp), .fma_negz(fmaNegz),
    .fma_roundmode(fmaRoundmode), .fma_result(fmaResult), .fma_flags(fmaFlags),
    .out_valid(outValid), .out_ready(outReady), .out_record(outRecord), .rec_count(recCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Deterministic stand-in for the external fma16, driven from the DUT's fma_* pins.
  assign fmaResult = fmaY ^ (fmaX - 16'h3C00) ^ fmaZ ^ {fmaAdd, ~fmaMul, 14'b0};
  assign fmaFlags  = fmaX[3:0] ^ fmaZ[3:0] ^ {fmaRoundmode, fmaNegp, fmaNegz};

  // Same stub expressed from the raw control byte layout.
  function automatic logic [19:0] refStub(input logic [15:0] x, y, z, input logic [7:0] c);
    logic [15:0] r;
    logic [3:0]  f;
    r = y ^ (x - 16'h3C00) ^ z ^ {c[2], ~c[3], 14'b0};
    f = x[3:0] ^ z[3:0] ^ {c[5:4], c[1], c[0]};
    return {r, f};
  endfunction

  logic [75:0] mq[$];
  bit          mEval;
  logic [75:0] mPending;
  logic [15:0] mX, mY, mZ, mCount;
  logic [7:0]  mCtrl;

  function automatic void modelClear();
    mq.delete();
    mEval = 0;
    mPending = '0;
    mX = '0; mY = '0; mZ = '0; mCtrl = '0; mCount = '0;
  endfunction

  task automatic checkOutput(input string name, input logic [75:0] act, input logic [75:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit rstN, input bit v, input logic [15:0] x, y, z,
                               input logic [7:0] c, input bit oRdy);
    bit accept, pop;
    @(negedge clk);
    reset = rstN; inValid = v; inX = x; inY = y; inZ = z; inCtrl = c; outReady = oRdy;
    #1;
    checkOutput("in_ready", 76'(inReady), 76'(!mEval && mq.size() < DEPTH));
    checkOutput("out_valid", 76'(outValid), 76'(mq.size() != 0));
    checkOutput("rec_count", 76'(recCount), 76'(mCount));
    checkOutput("fma_xyz", 76'({fmaX, fmaY, fmaZ}), 76'({mX, mY, mZ}));
    checkOutput("fma_ctrl", 76'({fmaRoundmode, fmaMul, fmaAdd, fmaNegp, fmaNegz}), 76'(mCtrl[5:0]));
    if (mq.size() != 0) checkOutput("out_record", outRecord, mq[0]);
    @(posedge clk);
    if (!rstN) begin
      modelClear();
    end else begin
      accept = !mEval && v && (mq.size() < DEPTH);
      pop    = (mq.size() != 0) && oRdy;
      if (pop) void'(mq.pop_front());
      if (mEval) begin
        mq.push_back(mPending);
        if (mCount != 16'hFFFF) mCount = mCount + 16'd1;
        mEval = 0;
      end else if (accept) begin
        mX = x; mY = y; mZ = z; mCtrl = c;
        mPending = {x, y, z, c, refStub(x, y, z, c)};
        mEval = 1;
      end
    end
  endtask

  task automatic idle(input bit oRdy);
    applyStimulus(1, 0, 16'h0, 16'h0, 16'h0, 8'h0, oRdy);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0; inValid = 1'b0; outReady = 1'b0;
    repeat (2) @(posedge clk);
    modelClear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [15:0] x, y, z;
    logic [7:0]  ctrl;
    logic [15:0] res;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [15:0] bx, by, bz;
    logic [7:0]  bc;
    reset = 1'b0; inValid = 1'b0; outReady = 1'b0;
    inX = '0; inY = '0; inZ = '0; inCtrl = '0;

    vecs[0] = '{16'h3C00, 16'h4000, 16'h0000, 8'h08, 16'h4000, 4'h0};
    vecs[1] = '{16'h3C00, 16'h1234, 16'h0000, 8'hC4, 16'hD234, 4'h0};
    vecs[2] = '{16'h3C05, 16'h0000, 16'h000A, 8'h3B, 16'h000F, 4'h0};
    vecs[3] = '{16'h4001, 16'hFFFF, 16'h0002, 8'h5E, 16'h7BFC, 4'h5};

    doReset();
    #1;
    checkOutput("reset_in_ready", 76'(inReady), 76'(1));
    checkOutput("reset_out_valid", 76'(outValid), 76'(0));
    checkOutput("reset_rec_count", 76'(recCount), 76'(0));
    checkOutput("reset_fma", 76'({fmaX, fmaY, fmaZ, fmaRoundmode, fmaMul, fmaAdd, fmaNegp, fmaNegz}), 76'(0));

    // Directed table: accept, evaluate, then the record must appear two edges after accept.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].ctrl, 0);
      applyStimulus(1, 0, 16'h0, 16'h0, 16'h0, 8'h0, 0);
      #1;
      checkOutput("table_valid", 76'(outValid), 76'(1));
      checkOutput("table_record", outRecord,
                  {vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].ctrl, vecs[i].res, vecs[i].flags});
      checkOutput("table_count", 76'(recCount), 76'(i + 1));
      idle(1);
    end

    // Fill with the consumer stalled, then drain in order.
    doReset();
    for (int i = 0; i < 2 * (DEPTH + 3); i++)
      applyStimulus(1, 1, 16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 0);
    #1;
    checkOutput("fill_count", 76'(recCount), 76'(DEPTH));
    checkOutput("fill_in_ready", 76'(inReady), 76'(0));
    for (int i = 0; i < DEPTH + 2; i++) idle(1);
    #1;
    checkOutput("drain_out_valid", 76'(outValid), 76'(0));

    // Push and pop on the same edge with one record already queued.
    applyStimulus(1, 1, 16'h1111, 16'h2222, 16'h3333, 8'h44, 0);
    idle(0);
    bx = 16'hABCD; by = 16'h3C00; bz = 16'h0F0F; bc = 8'h9D;
    applyStimulus(1, 1, bx, by, bz, bc, 0);
    idle(1);
    #1;
    checkOutput("simul_valid", 76'(outValid), 76'(1));
    checkOutput("simul_record", outRecord, {bx, by, bz, bc, refStub(bx, by, bz, bc)});
    idle(1);
    #1;
    checkOutput("simul_empty", 76'(outValid), 76'(0));

    // Reset arriving while a vector is being evaluated.
    applyStimulus(1, 1, 16'h5555, 16'h6666, 16'h7777, 8'h3F, 0);
    applyStimulus(0, 0, 16'h0, 16'h0, 16'h0, 8'h0, 0);
    #1;
    checkOutput("midreset_count", 76'(recCount), 76'(0));
    checkOutput("midreset_valid", 76'(outValid), 76'(0));
    checkOutput("midreset_fma_x", 76'(fmaX), 76'(0));
    idle(0);

    // Saturation: preload the counter just below its ceiling, then keep pushing with drain.
    doReset();
    @(negedge clk);
    force dut.recCount_q = 16'hFFFD;
    #1 release dut.recCount_q;
    mCount = 16'hFFFD;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 1);
      idle(1);
    end
    #1;
    checkOutput("sat_count", 76'(recCount), 76'(16'hFFFF));

    // Random traffic with occasional resets.
    doReset();
    for (int i = 0; i < 800; i++)
      applyStimulus(($urandom_range(0, 63) != 0), ($urandom_range(0, 9) < 7),
                    16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) != 0) && (i % 200 < 150));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
